if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//   Instruction-fetch stage between the PC and the decode stage. Owns the fetch PC,
//   drives the combinational instruction ROM (ce/addr in, inst out in the same cycle),
//   and buffers fetched {pc, inst} pairs in a small FIFO.
//   Decode consumes the FIFO through a valid/ready handshake.
//   A branch redirect flushes the queue and restarts fetch at the branch target.
// PARAMETERS
//   DEPTH     4       queue entries; power of 2, >= 2
//   RESET_PC  32'h0   first fetch address after reset; word aligned
//   LVL_W     3       width of level_o; equals clog2(DEPTH+1)
// PORTS
//   clk              in   1      system clock, rising edge
//   rst              in   1      asynchronous reset, active high
//   rom_ce           out  1      ROM chip enable (registered)
//   rom_addr         out  32     ROM byte address; always equals fetch_pc
//   rom_inst         in   32     ROM data, valid in the same cycle as rom_addr
//   branch_flag_i    in   1      redirect request, sampled at the clock edge
//   branch_target_i  in   32     redirect address; bits [1:0] ignored
//   id_valid         out  1      head entry is valid
//   id_ready         in   1      decode accepts the head entry
//   id_pc            out  32     PC of the head entry
//   id_inst          out  32     instruction of the head entry
//   level_o          out  LVL_W  number of occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (asynchronous, immediate):
//       rom_ce=0, fetch_pc=RESET_PC, queue empty, level_o=0, id_valid=0.
//       id_pc=0 and id_inst=0. Read/write pointers=0.
//   - Power-up: rom_ce goes to 1 at the first edge after rst deasserts; no push on that edge.
//   - Push: occurs at an edge when all of the following hold:
//       rom_ce=1, !branch_flag_i, and (level<DEPTH or pop on the same edge).
//       The write stores {rom_addr, rom_inst}; fetch_pc then advances by 4.
//   - Hold: if no push occurs, fetch_pc holds and rom_ce stays 1.
//   - Pop: occurs at an edge where id_valid && id_ready; the read pointer advances.
//   - Outputs: id_valid = (level!=0). id_pc and id_inst show the head entry,
//     and are forced to 0 when the queue is empty (combinational from the queue regs).
//   - Latency:
//       RESET_PC appears on the id_* outputs after the 2nd edge following reset release.
//       In steady state, with id_ready=1, one instruction is delivered per cycle.
//   - Full with pop and push on the same edge: both are performed and level is unchanged.
//   - Empty: pop is impossible, since id_valid=0.
//   - Branch at an edge:
//       All entries are discarded (level=0, pointers=0).
//       fetch_pc <= {branch_target_i[31:2], 2'b00}.
//       No push occurs on that edge. A simultaneous pop is a legal, completed transfer.
//   - Post-redirect: first target instruction is on id_* after the next edge (1 bubble).
//   - Wrap-around:
//       Pointers wrap modulo DEPTH.
//       fetch_pc wraps from 32'hFFFF_FFFC to 32'h0 with no error flag.
//   - Reset mid-operation: everything clears at once, regardless of clk.
//     Any in-flight entries are lost.
// CONFIGURATION
//   IFQ_STATS_EN defined: adds two outputs.
//     fetch_cnt_o [31:0]: increments on every push.
//     flush_cnt_o [31:0]: increments on every edge with branch_flag_i=1.
//     Both counters clear on rst and wrap at 2^32.
//   IFQ_STATS_EN undefined: the ports and counters do not exist.
//     Behaviour is otherwise identical.
// TESTING
//   1. ROM word i holds value i; id_ready=1; release rst.
//      -> id_valid=1 after the 2nd edge.
//      -> id_pc = 0,4,8,C and id_inst = 0,1,2,3 on consecutive cycles.
//   2. id_ready=0 for 10 cycles after reset.
//      -> level_o saturates at 4; rom_addr holds at 32'h10.
//      -> After id_ready=1, id_pc = 0,4,8,C,10 in order, with no gaps or duplicates.
//   3. level_o=3 and branch_flag_i=1 with target 32'h43 for one edge.
//      -> Next cycle: level_o=0, rom_addr=32'h40.
//      -> One edge later: id_pc=32'h40, id_inst = ROM[16].
//   4. Queue full and id_ready=1 on the same edge.
//      -> level_o stays 4, one entry delivered, fetch_pc advances by 4.
//   5. Assert rst between clock edges mid-stream.
//      -> rom_ce=0, id_valid=0, level_o=0 immediately.
//      -> After release, fetch restarts at RESET_PC.
//   6. IFQ_STATS_EN defined, run scenarios 1 and 3.
//      -> flush_cnt_o=1, and fetch_cnt_o equals the number of observed pushes.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage: owns the fetch PC, drives a combinational
//   instruction ROM and buffers fetched {pc, inst} pairs in a small FIFO that
//   decode drains through a valid/ready handshake. A branch redirect flushes
//   the queue and restarts fetch at the (word-aligned) branch target.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   rom_ce            ROM chip enable (registered)
//   rom_addr          ROM byte address, equals the fetch PC
//   rom_inst          ROM data, valid in the same cycle as rom_addr
//   branch_flag_i     redirect request, sampled at the clock edge
//   branch_target_i   redirect address, bits [1:0] ignored
//   id_valid          head entry is valid
//   id_ready          decode accepts the head entry
//   id_pc, id_inst    head entry contents, zero when the queue is empty
//   level_o           number of occupied entries, 0..DEPTH
//   fetch_cnt_o       (IFQ_STATS_EN only) push counter
//   flush_cnt_o       (IFQ_STATS_EN only) redirect counter
//
// Configuration
//   Define IFQ_STATS_EN to add the fetch/flush statistics counters.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned LVL_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rom_ce,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_inst,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_target_i,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic [LVL_W-1:0] level_o
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]      fetch_cnt_o,
  output logic [31:0]      flush_cnt_o
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic             pop;
  logic             push;
  logic [LVL_W-1:0] level_nxt;

  // Low target bits are architecturally ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target_i[1:0];

  // Handshake and push qualification; a pop frees a slot on the same edge.
  always_comb begin
    pop  = id_valid && id_ready;
    push = rom_ce && !branch_flag_i && ((level < LVL_W'(DEPTH)) || pop);
  end

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Fetch PC, ROM enable, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce   <= 1'b0;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
    end else begin
      rom_ce <= 1'b1;
      if (branch_flag_i) begin
        fetch_pc <= {branch_target_i[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        level    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        level <= level_nxt;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted in level.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= rom_inst;
    end
  end

  // Head-of-queue view, zeroed when empty.
  always_comb begin
    id_valid = (level != '0);
    id_pc    = id_valid ? pc_mem[rd_ptr]   : 32'h0;
    id_inst  = id_valid ? inst_mem[rd_ptr] : 32'h0;
  end

  assign rom_addr = fetch_pc;
  assign level_o  = level;

`ifdef IFQ_STATS_EN
  // Statistics counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o <= 32'h0;
      flush_cnt_o <= 32'h0;
    end else begin
      if (push) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if (branch_flag_i) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
